// File: rtl/mult_div_ctrl.sv
// Multi-cycle MIPS-style HI/LO unit: mult/multu/div/divu with a fixed busy window and mthi/mtlo.
// Result is computed at accept, held in a shadow, and committed to hi/lo when the down-counter expires.
module mult_div_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, MBUSY, DBUSY} state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] shadow;

    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] prod;
    logic [63:0] result;

    // Division works on magnitudes; signs are reapplied so the quotient truncates toward zero
    // and the remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        is_signed = ~md_op[0];
        a_neg     = is_signed & srcA[31];
        b_neg     = is_signed & srcB[31];
        mag_a     = a_neg ? (32'd0 - srcA) : srcA;
        mag_b     = b_neg ? (32'd0 - srcB) : srcB;
        uq        = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
        ur        = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
        quo       = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        rem       = a_neg ? (32'd0 - ur) : ur;
        if (srcB == 32'd0) begin
            quo = 32'hFFFF_FFFF;
            rem = srcA;
        end
        if (is_signed)
            prod = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
        else
            prod = {32'd0, srcA} * {32'd0, srcB};
        result = md_op[1] ? {rem, quo} : prod;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            shadow <= 64'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !req) begin
                        shadow <= result;
                        if (md_op[1]) begin
                            state <= DBUSY;
                            cnt   <= DIV_CNT;
                        end else begin
                            state <= MBUSY;
                            cnt   <= MULT_CNT;
                        end
                    end else if (!req) begin
                        if (mthi) hi <= srcA;
                        if (mtlo) lo <= srcA;
                    end
                end
                default: begin
                    // req does not abort an in-flight op; it always commits
                    if (cnt == 4'd0) begin
                        hi    <= shadow[63:32];
                        lo    <= shadow[31:0];
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign stall = md_use_D & (busy | (start & ~req));

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Bench for mult_div_ctrl: directed cases with literal expectations plus randomized traffic
// compared each cycle against a behavioural HI/LO model.
module tb_mult_div_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        start;
    logic [1:0]  md_op;
    logic        mthi;
    logic        mtlo;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        md_use_D;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .md_op(md_op),
        .mthi(mthi), .mtlo(mtlo), .srcA(srcA), .srcB(srcB), .md_use_D(md_use_D),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int busy_seen = 0;
    logic last_stall;

    // behavioural model state
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    int          m_rem;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned up;
        case (op)
            2'b00: begin sa = $signed(a); sb = $signed(b); q = sa * sb; return q; end
            2'b01: begin up = {32'd0, a}; up = up * {32'd0, b}; return up; end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                sa = $signed(a); sb = $signed(b);
                q = sa / sb; r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic step(input logic rst, input logic st, input logic rq, input logic mh, input logic ml,
                        input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic ud);
        @(negedge clk);
        reset = rst; start = st; req = rq; mthi = mh; mtlo = ml;
        md_op = op; srcA = a; srcB = b; md_use_D = ud;
        if (!rst) begin
            m_hi = 0; m_lo = 0; m_pend = 0; m_rem = 0;
        end
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_rem > 0});
        chk("stall", {31'd0, stall}, {31'd0, ud & ((m_rem > 0) | (st & ~rq))});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (busy) busy_seen++;
        last_stall = stall;
        @(posedge clk);
        if (rst) begin
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi = m_pend[63:32];
                    m_lo = m_pend[31:0];
                end
            end else if (!rq) begin
                if (st) begin
                    m_pend = model_op(op, a, b);
                    m_rem  = op[1] ? 10 : 5;
                end else begin
                    if (mh) m_hi = a;
                    if (ml) m_lo = a;
                end
            end
        end
    endtask

    task automatic idle(input int n, input logic ud);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, ud);
    endtask

    task automatic op_run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int cyc, input logic [31:0] ehi, input logic [31:0] elo, input string name);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, op, a, b, 1'b0);
        busy_seen = 0;
        idle(cyc, 1'b0);
        #1;
        chk({name, "_busy_cycles"}, busy_seen, cyc);
        chk({name, "_hi"}, hi, ehi);
        chk({name, "_lo"}, lo, elo);
    endtask

    logic [31:0] ra, rb;

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            4: return 32'd0 - $urandom_range(1, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b0; req = 0; start = 0; md_op = 0; mthi = 0; mtlo = 0;
        srcA = 0; srcB = 0; md_use_D = 0;
        m_hi = 0; m_lo = 0; m_pend = 0; m_rem = 0;

        // reset holds everything at zero, even with start asserted
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h1234, 32'd3, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h1234, 32'd3, 1'b1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        idle(2, 1'b0);

        op_run(2'b00, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult");
        op_run(2'b01, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA, "multu");
        op_run(2'b10, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        op_run(2'b11, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF, "divu0");
        op_run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, "divovf");
        op_run(2'b10, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF, "div0");

        // cancelled start
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 32'd9, 32'd9, 1'b1);
        chk("req_start_stall", {31'd0, last_stall}, 32'd0);
        idle(1, 1'b1);
        #1;
        chk("req_start_busy", {31'd0, busy}, 32'd0);
        chk("req_start_lo", lo, 32'hFFFF_FFFF);

        // stall window with req pulsed mid-op
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'd100, 32'd7, 1'b1);
        chk("stall_start", {31'd0, last_stall}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1);
        idle(3, 1'b1);
        chk("stall_last_busy", {31'd0, last_stall}, 32'd1);
        idle(1, 1'b1);
        chk("stall_after", {31'd0, last_stall}, 32'd0);
        chk("req_mid_lo", lo, 32'd700);

        // mthi/mtlo, then start wins over simultaneous mtlo
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h1234_5678, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h9ABC_DEF0, 32'd0, 1'b0);
        #1;
        chk("mthi", hi, 32'h1234_5678);
        chk("mtlo", lo, 32'h9ABC_DEF0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'd2, 32'd3, 1'b0);
        #1;
        chk("start_mtlo_hold", lo, 32'h9ABC_DEF0);
        idle(5, 1'b0);
        #1;
        chk("start_mtlo_lo", lo, 32'd6);

        // reset on busy cycle 3 of a div discards it
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 32'd100, 32'd3, 1'b0);
        idle(2, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 0; m_lo = 0; m_pend = 0; m_rem = 0;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        idle(15, 1'b0);
        #1;
        chk("rst_no_commit_lo", lo, 32'd0);
        chk("rst_no_commit_hi", hi, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ra = pick();
            rb = pick();
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                 ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_ctrl.md
MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy cycles for div/divu.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  exception/interrupt flush; high = current E-stage instruction is cancelled.
REQ-006 start  input  1  E-stage mult/div instruction valid this cycle.
REQ-007 md_op  input  2  00 mult, 01 multu, 10 div, 11 divu.
REQ-008 mthi  input  1  E-stage mthi valid.
REQ-009 mtlo  input  1  E-stage mtlo valid.
REQ-010 srcA  input  32  rs operand (dividend / multiplicand / mthi-mtlo data).
REQ-011 srcB  input  32  rt operand (divisor / multiplier).
REQ-012 md_use_D  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-013 busy  output  1  operation in flight.
REQ-014 stall  output  1  stall request to hazard unit.
REQ-015 hi  output  32  HI register.
REQ-016 lo  output  32  LO register.

Function
REQ-017 States: IDLE, MBUSY, DBUSY; 4-bit down-counter cnt; 64-bit result shadow.
REQ-018 Start accepted only when state IDLE, start=1, req=0; otherwise start ignored.
REQ-019 On accept: operands evaluated, result latched into shadow, cnt loaded with MULT_CYCLES-1 (MBUSY) or DIV_CYCLES-1 (DBUSY).
REQ-020 busy = (state != IDLE); rises at the accepting edge, stays high exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-021 In MBUSY/DBUSY: cnt decrements each edge; at the edge where cnt==0, hi/lo take shadow and state returns to IDLE in the same edge.
REQ-022 mult: signed 64-bit product of srcA*srcB, hi=[63:32], lo=[31:0]; multu: same unsigned.
REQ-023 div: lo=signed quotient truncated toward zero, hi=remainder with dividend sign; divu: unsigned.
REQ-024 Divisor 0 (div/divu): lo=0xFFFFFFFF, hi=srcA.
REQ-025 div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
REQ-026 mthi/mtlo in IDLE with req=0: hi or lo <= srcA at next edge; both asserted: both written.
REQ-027 mthi/mtlo while busy or with req=1: ignored (hazard unit guarantees not issued while busy).
REQ-028 start and mthi/mtlo simultaneously: start wins, mthi/mtlo ignored.
REQ-029 stall = md_use_D & (busy | (start & ~req)); combinational.
REQ-030 req during MBUSY/DBUSY does not abort; in-flight op completes and commits.
REQ-031 hi/lo unchanged in every cycle except commit or accepted mthi/mtlo.

Reset
REQ-032 reset=0 forces immediately: state IDLE, cnt 0, shadow 0, hi 0, lo 0, busy 0.
REQ-033 reset mid-operation: operation discarded, no commit, hi/lo 0.
REQ-034 First accepted start is the first edge with reset=1 and start=1.

Verification
REQ-035 mult srcA=0xFFFFFFFE, srcB=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-036 div srcA=0xFFFFFFF9 (-7), srcB=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/0 -> lo=0xFFFFFFFF, hi=7.
REQ-037 start with req=1 -> busy stays 0, hi/lo unchanged, stall=0 even if md_use_D=1.
REQ-038 mult in flight, md_use_D=1 each cycle -> stall=1 from start cycle through last busy cycle, 0 the cycle after commit; req pulsed mid-op -> commit still occurs.
REQ-039 mthi srcA=0x12345678 then mtlo srcA=0x9ABCDEF0 in IDLE -> hi=0x12345678, lo=0x9ABCDEF0; start+mtlo same cycle -> lo gets only the op result.
REQ-040 reset=0 asserted on busy cycle 3 of div -> busy, hi, lo 0 immediately; no later commit after reset release.
